// File: rtl/uart_16450.sv
// uart_16450 - 16450-style UART with a fixed 8N1 frame.
//
// State table (TX and RX share the same encoding style)
//   state | meaning
//   IDLE  | TX: line high, waiting for THRE=0 / RX: waiting for rxd low
//   START | TX: driving start bit / RX: start bit, glitch check at tick 8
//   DATA  | 8 data bits, LSB first
//   STOP  | TX: driving stop bit / RX: waiting for mid-stop sample
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   UARTaddr   register select (0 RBR/THR/DLL, 1 IER/DLM, 2 IIR, 3 LCR,
//              5 LSR, 7 SCR)
//   UARTwrite  write data
//   UARTread   combinational read data
//   UARTce     chip enable qualifying UARTwe / UARTre
//   UARTwe     write strobe
//   UARTre     read strobe (side effects at the clock edge)
//   rxd        asynchronous serial input, idle high
//   txd        serial output, idle high
//   irq        level interrupt, active high
module uart_16450 #(
  parameter logic [15:0] DEFAULT_DIV = 16'd27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] UARTaddr,
  input  logic [7:0] UARTwrite,
  output logic [7:0] UARTread,
  input  logic       UARTce,
  input  logic       UARTwe,
  input  logic       UARTre,
  input  logic       rxd,
  output logic       txd,
  output logic       irq
);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic [7:0]  r_dll, r_dlm, r_lcr, r_scr, r_rbr, r_thr;
  logic [1:0]  r_ier;
  logic        r_thre, r_dr, r_oe, r_fe;
  logic [15:0] r_presc;
  logic        r_rx_s1, r_rx_s2;

  state_t      r_tx_state, w_tx_next;
  logic [3:0]  r_tx_tcnt;
  logic [2:0]  r_tx_bcnt;
  logic [7:0]  r_tx_shift;
  logic        w_tx_load;

  state_t      r_rx_state, w_rx_next;
  logic [3:0]  r_rx_tcnt;
  logic [2:0]  r_rx_bcnt;
  logic [7:0]  r_rx_shift;
  logic        w_rx_done;

  logic        w_dlab, w_wr, w_rd;
  logic        w_wr_thr, w_wr_dll, w_wr_ier, w_wr_dlm, w_wr_lcr, w_wr_scr;
  logic        w_rd_rbr, w_rd_lsr;
  logic [15:0] w_div;
  logic        w_tick, w_tx_bit_end, w_rx_mid_start, w_rx_sample, w_temt;
  logic [7:0]  w_lsr, w_iir;

  assign w_dlab   = r_lcr[7];
  assign w_wr     = UARTce & UARTwe;
  assign w_rd     = UARTce & UARTre;
  assign w_wr_thr = w_wr & (UARTaddr == 3'd0) & ~w_dlab;
  assign w_wr_dll = w_wr & (UARTaddr == 3'd0) &  w_dlab;
  assign w_wr_ier = w_wr & (UARTaddr == 3'd1) & ~w_dlab;
  assign w_wr_dlm = w_wr & (UARTaddr == 3'd1) &  w_dlab;
  assign w_wr_lcr = w_wr & (UARTaddr == 3'd3);
  assign w_wr_scr = w_wr & (UARTaddr == 3'd7);
  assign w_rd_rbr = w_rd & (UARTaddr == 3'd0) & ~w_dlab;
  assign w_rd_lsr = w_rd & (UARTaddr == 3'd5);

  // Divisor 0 is treated as 1. The prescaler is a down-counter whose
  // terminal count (zero) is the 16x tick.
  assign w_div  = ({r_dlm, r_dll} == 16'd0) ? 16'd1 : {r_dlm, r_dll};
  assign w_tick = (r_presc == 16'd0);

  always_ff @(posedge clk) begin
    if (reset || w_wr_dll || w_wr_dlm) r_presc <= 16'd0;
    else if (w_tick)                   r_presc <= w_div - 16'd1;
    else                               r_presc <= r_presc - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dll <= DEFAULT_DIV[7:0];
      r_dlm <= DEFAULT_DIV[15:8];
      r_lcr <= 8'h03;
      r_ier <= 2'b00;
      r_scr <= 8'h00;
    end else begin
      if (w_wr_dll) r_dll <= UARTwrite;
      if (w_wr_dlm) r_dlm <= UARTwrite;
      if (w_wr_lcr) r_lcr <= UARTwrite;
      if (w_wr_ier) r_ier <= UARTwrite[1:0];
      if (w_wr_scr) r_scr <= UARTwrite;
    end
  end

  // A THR write in the same cycle as a transfer wins, so that byte is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_thr  <= 8'h00;
      r_thre <= 1'b1;
    end else begin
      if (w_tx_load) r_thre <= 1'b1;
      if (w_wr_thr) begin
        r_thr  <= UARTwrite;
        r_thre <= 1'b0;
      end
    end
  end

  // ---------------- transmitter ----------------
  assign w_tx_bit_end = w_tick & (r_tx_tcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) r_tx_state <= ST_IDLE;
    else       r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_load = 1'b0;
    case (r_tx_state)
      ST_IDLE:  if (!r_thre) begin
                  w_tx_next = ST_START;
                  w_tx_load = 1'b1;
                end
      ST_START: if (w_tx_bit_end) w_tx_next = ST_DATA;
      ST_DATA:  if (w_tx_bit_end && r_tx_bcnt == 3'd7) w_tx_next = ST_STOP;
      ST_STOP:  if (w_tx_bit_end) begin
                  // Back-to-back frame when THR was reloaded during this one.
                  if (!r_thre) begin
                    w_tx_next = ST_START;
                    w_tx_load = 1'b1;
                  end else begin
                    w_tx_next = ST_IDLE;
                  end
                end
      default:  w_tx_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_tcnt  <= 4'd0;
      r_tx_bcnt  <= 3'd0;
      r_tx_shift <= 8'h00;
    end else if (w_tx_load) begin
      r_tx_tcnt  <= 4'd0;
      r_tx_bcnt  <= 3'd0;
      r_tx_shift <= r_thr;
    end else if (r_tx_state != ST_IDLE && w_tick) begin
      r_tx_tcnt <= r_tx_tcnt + 4'd1;
      if (w_tx_bit_end && r_tx_state == ST_DATA) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bcnt  <= r_tx_bcnt + 3'd1;
      end
    end
  end

  assign txd = (r_tx_state == ST_START) ? 1'b0 :
               (r_tx_state == ST_DATA)  ? r_tx_shift[0] : 1'b1;

  // ---------------- receiver ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx_mid_start = w_tick & (r_rx_tcnt == 4'd7);
  assign w_rx_sample    = w_tick & (r_rx_tcnt == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) r_rx_state <= ST_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    case (r_rx_state)
      ST_IDLE:  if (!r_rx_s2) w_rx_next = ST_START;
      ST_START: if (w_rx_mid_start) w_rx_next = r_rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_rx_sample && r_rx_bcnt == 3'd7) w_rx_next = ST_STOP;
      ST_STOP:  if (w_rx_sample) begin
                  w_rx_next = ST_IDLE;
                  w_rx_done = 1'b1;
                end
      default:  w_rx_next = ST_IDLE;
    endcase
  end

  // Restarting the tick count at mid-start puts every later sample mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_tcnt  <= 4'd0;
      r_rx_bcnt  <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (r_rx_state == ST_IDLE) begin
      r_rx_tcnt <= 4'd0;
      r_rx_bcnt <= 3'd0;
    end else if (w_tick) begin
      if (r_rx_state == ST_START && r_rx_tcnt == 4'd7) r_rx_tcnt <= 4'd0;
      else                                             r_rx_tcnt <= r_rx_tcnt + 4'd1;
      if (r_rx_state == ST_DATA && w_rx_sample) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bcnt  <= r_rx_bcnt + 3'd1;
      end
    end
  end

  // Later assignments win: a completing byte keeps DR set through an RBR read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rbr <= 8'h00;
      r_dr  <= 1'b0;
      r_oe  <= 1'b0;
      r_fe  <= 1'b0;
    end else begin
      if (w_rd_rbr) r_dr <= 1'b0;
      if (w_rd_lsr) begin
        r_oe <= 1'b0;
        r_fe <= 1'b0;
      end
      if (w_rx_done) begin
        r_rbr <= r_rx_shift;
        r_dr  <= 1'b1;
        if (!r_rx_s2)          r_fe <= 1'b1;
        if (r_dr && !w_rd_rbr) r_oe <= 1'b1;
      end
    end
  end

  // ---------------- status / read path ----------------
  assign w_temt = r_thre & (r_tx_state == ST_IDLE);
  assign w_lsr  = {1'b0, w_temt, r_thre, 1'b0, r_fe, 1'b0, r_oe, r_dr};
  assign w_iir  = (r_ier[0] & r_dr)   ? 8'h04 :
                  (r_ier[1] & r_thre) ? 8'h02 : 8'h01;
  assign irq    = (r_ier[0] & r_dr) | (r_ier[1] & r_thre);

  always_comb begin
    UARTread = 8'h00;
    case (UARTaddr)
      3'd0:    UARTread = w_dlab ? r_dll : r_rbr;
      3'd1:    UARTread = w_dlab ? r_dlm : {6'b0, r_ier};
      3'd2:    UARTread = w_iir;
      3'd3:    UARTread = r_lcr;
      3'd5:    UARTread = w_lsr;
      3'd7:    UARTread = r_scr;
      default: UARTread = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_16450.sv
// tb_uart_16450 - scoreboard bench for uart_16450 (DEFAULT_DIV = 1).
// Stimulus pushes expected read data and expected transmitted bytes into
// queues; negedge monitors pop and compare when the DUT presents them.
module tb_uart_16450;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] UARTaddr = 3'd0;
  logic [7:0] UARTwrite = 8'h00;
  logic [7:0] UARTread;
  logic       UARTce = 1'b0, UARTwe = 1'b0, UARTre = 1'b0;
  logic       rxd = 1'b1;
  logic       txd, irq;

  int checks = 0;
  int failures = 0;
  int bitc = 16;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic [7:0] tx_exp_q[$];

  uart_16450 #(.DEFAULT_DIV(16'd1)) dut (
    .clk(clk), .reset(reset), .UARTaddr(UARTaddr), .UARTwrite(UARTwrite),
    .UARTread(UARTread), .UARTce(UARTce), .UARTwe(UARTwe), .UARTre(UARTre),
    .rxd(rxd), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Read monitor
  always @(negedge clk) begin : rd_mon
    logic [7:0] e;
    string n;
    if (!reset && UARTce && UARTre) begin
      if (rd_exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: got read 0x%0h with no expectation", UARTread);
      end else begin
        e = rd_exp_q.pop_front();
        n = rd_name_q.pop_front();
        chk(n, {24'd0, UARTread}, {24'd0, e});
      end
    end
  end

  // TX monitor: samples each bit near its start and its end
  logic       tx_busy = 1'b0;
  int         tx_cnt = 0;
  logic [9:0] tx_lo, tx_hi;

  always @(negedge clk) begin : tx_mon
    int b, off, olo, ohi;
    logic [7:0] e;
    if (reset) begin
      tx_busy = 1'b0;
    end else begin
      if (!tx_busy && txd == 1'b0) begin
        tx_busy = 1'b1; tx_cnt = 0; tx_lo = '0; tx_hi = '0;
      end
      if (tx_busy) begin
        b   = tx_cnt / bitc;
        off = tx_cnt % bitc;
        olo = (bitc == 16) ? 0 : 1;
        ohi = (bitc == 16) ? 15 : bitc - 2;
        if (off == olo) tx_lo[b] = txd;
        if (off == ohi) begin
          tx_hi[b] = txd;
          if (b == 9) begin
            tx_busy = 1'b0;
            if (tx_exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL tx_unexpected_frame: got frame 0x%0h expected no frame", tx_hi[8:1]);
            end else begin
              e = tx_exp_q.pop_front();
              chk("tx_data_early", {24'd0, tx_lo[8:1]}, {24'd0, e});
              chk("tx_data_late",  {24'd0, tx_hi[8:1]}, {24'd0, e});
              chk("tx_start_stop", {28'd0, tx_lo[9], tx_hi[9], tx_lo[0], tx_hi[0]}, 32'hC);
            end
          end
        end
        tx_cnt++;
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    UARTaddr = a; UARTwrite = d; UARTce = 1'b1; UARTwe = 1'b1;
    @(posedge clk); #1;
    UARTce = 1'b0; UARTwe = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] e, input string nm);
    @(posedge clk); #1;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(nm);
    UARTaddr = a; UARTce = 1'b1; UARTre = 1'b1;
    @(posedge clk); #1;
    UARTce = 1'b0; UARTre = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (bitc) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (bitc) @(posedge clk);
    end
    #1 rxd = stop_bit;
    repeat (bitc) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_txd", {31'd0, txd}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd(3'd5, 8'h60, "reset_lsr");
    rd(3'd2, 8'h01, "reset_iir");
    rd(3'd3, 8'h03, "reset_lcr");
    rd(3'd1, 8'h00, "reset_ier");
    rd(3'd0, 8'h00, "reset_rbr");
    rd(3'd7, 8'h00, "reset_scr");
    rd(3'd4, 8'h00, "unmapped_addr4");
    rd(3'd6, 8'h00, "unmapped_addr6");
    wr(3'd3, 8'h83);
    rd(3'd0, 8'h01, "reset_dll");
    rd(3'd1, 8'h00, "reset_dlm");
    rd(3'd3, 8'h83, "lcr_dlab");
    wr(3'd3, 8'h03);
    wr(3'd7, 8'hA5);
    rd(3'd7, 8'hA5, "scr_rw");

    // single byte transmit
    tx_exp_q.push_back(8'h55);
    wr(3'd0, 8'h55);
    repeat (4) @(posedge clk);
    rd(3'd5, 8'h20, "lsr_during_tx");
    repeat (200) @(posedge clk);
    rd(3'd5, 8'h60, "lsr_after_tx");

    // back-to-back with holding-register overwrite
    tx_exp_q.push_back(8'h0F);
    tx_exp_q.push_back(8'h3C);
    wr(3'd0, 8'h0F);
    repeat (5) @(posedge clk);
    wr(3'd0, 8'hF0);
    wr(3'd0, 8'h3C);
    rd(3'd5, 8'h00, "lsr_thr_pending");
    repeat (400) @(posedge clk);
    rd(3'd5, 8'h60, "lsr_after_b2b");

    // receive
    send_rx(8'hA3, 1'b1);
    repeat (4) @(posedge clk);
    rd(3'd5, 8'h61, "lsr_rx_dr");
    rd(3'd0, 8'hA3, "rbr_a3");
    rd(3'd5, 8'h60, "lsr_after_rbr_read");

    // overrun
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    repeat (4) @(posedge clk);
    rd(3'd5, 8'h63, "lsr_overrun");
    rd(3'd5, 8'h61, "lsr_oe_cleared");
    rd(3'd0, 8'h22, "rbr_overwritten");
    rd(3'd5, 8'h60, "lsr_after_overrun");

    // framing error
    send_rx(8'h5A, 1'b0);
    repeat (20) @(posedge clk);
    rd(3'd5, 8'h69, "lsr_framing");
    rd(3'd5, 8'h61, "lsr_fe_cleared");
    rd(3'd0, 8'h5A, "rbr_5a");
    rd(3'd5, 8'h60, "lsr_after_fe");

    // interrupts
    wr(3'd1, 8'hFF);
    chk("irq_thre", {31'd0, irq}, 32'd1);
    rd(3'd1, 8'h03, "ier_masked");
    rd(3'd2, 8'h02, "iir_thre");
    send_rx(8'h3C, 1'b1);
    repeat (4) @(posedge clk);
    rd(3'd2, 8'h04, "iir_rx");
    chk("irq_rx", {31'd0, irq}, 32'd1);
    rd(3'd0, 8'h3C, "rbr_3c");
    rd(3'd2, 8'h02, "iir_after_read");
    wr(3'd1, 8'h00);
    chk("irq_off", {31'd0, irq}, 32'd0);
    rd(3'd2, 8'h01, "iir_none");

    // divisor 2: 32-clk bits, short glitch rejected
    wr(3'd3, 8'h83);
    wr(3'd0, 8'h02);
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h03);
    bitc = 32;
    tx_exp_q.push_back(8'hC5);
    wr(3'd0, 8'hC5);
    repeat (400) @(posedge clk);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (60) @(posedge clk);
    rd(3'd5, 8'h60, "lsr_glitch_no_dr");

    // divisor 0 behaves as 1
    wr(3'd3, 8'h83);
    wr(3'd0, 8'h00);
    rd(3'd0, 8'h00, "dll_zero");
    wr(3'd3, 8'h03);
    bitc = 16;
    tx_exp_q.push_back(8'h81);
    wr(3'd0, 8'h81);
    repeat (200) @(posedge clk);
    rd(3'd5, 8'h60, "lsr_after_div0");

    // reset mid-frame
    wr(3'd0, 8'h00);
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("txd_reset_midframe", {31'd0, txd}, 32'd1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd(3'd5, 8'h60, "lsr_after_reset");
    rd(3'd3, 8'h03, "lcr_after_reset");
    wr(3'd3, 8'h83);
    rd(3'd0, 8'h01, "dll_after_reset");
    wr(3'd3, 8'h03);
    repeat (300) @(posedge clk);

    chk("tx_queue_drained", tx_exp_q.size(), 32'd0);
    chk("rd_queue_drained", rd_exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
